// File: rtl/muldiv_seq_if.sv
// EX-stage handshake bundle between the pipeline and the RV32M sequencer.
// The master side is EX; the slave side is the sequencer.
interface muldiv_seq_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] opa;
   logic [XLEN-1:0] opb;
   logic            flush;
   logic            busy;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, funct3, opa, opb, flush,
      input  busy, stall, done, result
   );

   modport slave (
      input  start, funct3, opa, opb, flush,
      output busy, stall, done, result
   );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer.
// Shift-add multiply, restoring divide, one bit per cycle.
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input logic         clk,
   input logic         rst,
   muldiv_seq_if.slave bus
);
   localparam int CW = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t            state;
   state_t            state_n;
   logic [CW-1:0]     cnt;
   logic [2:0]        op;
   logic              neg_a;
   logic              neg_b;
   logic [XLEN-1:0]   opnd;
   logic [2*XLEN-1:0] acc;
   logic              done_q;
   logic [XLEN-1:0]   res_q;

   logic              in_div;
   logic              in_sa;
   logic              in_sb;
   logic              in_na;
   logic              in_nb;
   logic [XLEN-1:0]   mag_a;
   logic [XLEN-1:0]   mag_b;
   logic              div0;
   logic              ovf;
   logic [XLEN-1:0]   spec_res;

   logic [XLEN:0]     sum;
   logic [XLEN:0]     trial;
   logic [2*XLEN-1:0] acc_step;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   fix_res;

   logic              load;
   logic              step;
   logic              res_we;
   logic [XLEN-1:0]   res_d;
   logic              done_d;

   // Operand decode on the incoming instruction
   assign in_div = bus.funct3[2];
   assign in_sa  = in_div ? ~bus.funct3[0]
                          : (bus.funct3[1:0] != 2'b11);
   assign in_sb  = in_div ? ~bus.funct3[0] : ~bus.funct3[1];
   assign in_na  = in_sa & bus.opa[XLEN-1];
   assign in_nb  = in_sb & bus.opb[XLEN-1];
   assign mag_a  = in_na ? -bus.opa : bus.opa;
   assign mag_b  = in_nb ? -bus.opb : bus.opb;
   assign div0   = in_div & (bus.opb == '0);
   assign ovf    = in_div & ~bus.funct3[0]
                 & (bus.opa == MIN) & (bus.opb == '1);

   always_comb begin
      spec_res = '0;
      if (div0)
         spec_res = bus.funct3[1] ? bus.opa : '1;
      else
         spec_res = bus.funct3[1] ? '0 : MIN;
   end

   // Remainder is 33 bits wide after the shift, so trial uses acc[2X-1:X-1]
   assign sum   = {1'b0, acc[2*XLEN-1:XLEN]}
                + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
   assign trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};

   always_comb begin
      acc_step = {sum, acc[XLEN-1:1]};
      if (op[2]) begin
         if (trial[XLEN])
            acc_step = {acc[2*XLEN-2:0], 1'b0};
         else
            acc_step = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end
   end

   assign prod = (neg_a ^ neg_b) ? -acc : acc;
   assign quo  = acc[XLEN-1:0];
   assign rem  = acc[2*XLEN-1:XLEN];

   always_comb begin
      fix_res = '0;
      unique case (op)
         3'b000:  fix_res = prod[XLEN-1:0];
         3'b100:  fix_res = (neg_a ^ neg_b) ? -quo : quo;
         3'b101:  fix_res = quo;
         3'b110:  fix_res = neg_a ? -rem : rem;
         3'b111:  fix_res = rem;
         default: fix_res = prod[2*XLEN-1:XLEN];
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (bus.start) state_n = (div0 | ovf) ? DONE : CALC;
         CALC: if (cnt == CW'(XLEN-1)) state_n = FIX;
         FIX:  state_n = DONE;
         default: state_n = IDLE;
      endcase
      if (bus.flush) state_n = IDLE;
   end

   always_comb begin
      load   = 1'b0;
      step   = 1'b0;
      res_we = 1'b0;
      res_d  = fix_res;
      unique case (state)
         IDLE: begin
            load = bus.start & ~bus.flush;
            if (load & (div0 | ovf)) begin
               res_we = 1'b1;
               res_d  = spec_res;
            end
         end
         CALC:    step   = ~bus.flush;
         FIX:     res_we = ~bus.flush;
         default: ;
      endcase
      done_d = (state_n == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         op     <= '0;
         neg_a  <= 1'b0;
         neg_b  <= 1'b0;
         opnd   <= '0;
         acc    <= '0;
         done_q <= 1'b0;
         res_q  <= '0;
      end else begin
         done_q <= done_d;
         if (res_we) res_q <= res_d;
         if (load) begin
            op    <= bus.funct3;
            neg_a <= in_na;
            neg_b <= in_nb;
            cnt   <= '0;
            opnd  <= in_div ? mag_b : mag_a;
            acc   <= {{XLEN{1'b0}}, (in_div ? mag_a : mag_b)};
         end else if (step) begin
            acc <= acc_step;
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign bus.busy   = (state != IDLE);
   assign bus.done   = done_q;
   assign bus.result = res_q;
   assign bus.stall  = bus.start & ~done_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table plus flush,
// reset and back-to-back sequences.
module tb_muldiv_seq;
   logic clk;
   logic rst;

   muldiv_seq_if bus ();

   muldiv_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string       nm;
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      int          lat;
   } vec_t;

   vec_t tv[$];
   int   checks;
   int   errors;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add(input string nm, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input int lat);
      vec_t v;
      v.nm = nm; v.f = f; v.a = a; v.b = b; v.r = r; v.lat = lat;
      tv.push_back(v);
   endtask

   task automatic run_op(input vec_t v);
      int cyc;
      int stalls;
      bit got;
      @(posedge clk); #1;
      bus.funct3 = v.f;
      bus.opa    = v.a;
      bus.opb    = v.b;
      bus.start  = 1'b1;
      got = 0; stalls = 0; cyc = -1;
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge clk);
         if (bus.stall) stalls++;
         if (bus.done) begin
            got = 1;
            cyc = c;
            chk({v.nm, "_result"}, bus.result, v.r);
            bus.start = 1'b0;
         end else begin
            @(posedge clk); #1;
            // Operands must be ignored once accepted
            if (c == 0) begin
               bus.opa = ~v.a;
               bus.opb = ~v.b;
            end
         end
      end
      chk({v.nm, "_done_seen"}, 32'(got), 32'd1);
      chk({v.nm, "_latency"}, 32'(cyc), 32'(v.lat));
      chk({v.nm, "_stall_cycles"}, 32'(stalls), 32'(v.lat));
      @(negedge clk);
      chk({v.nm, "_done_pulse"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      logic [31:0] prior;
      bit seen;
      int ndone;
      int t1;
      int t2;
      checks = 0;
      errors = 0;
      rst = 1'b0;
      bus.start  = 1'b0;
      bus.flush  = 1'b0;
      bus.funct3 = 3'b000;
      bus.opa    = '0;
      bus.opb    = '0;

      add("mul",      3'b000, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
      add("mul_min",  3'b000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);
      add("mulh",     3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
      add("mulhu",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
      add("mulhsu",   3'b010, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 34);
      add("div",      3'b100, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 34);
      add("rem",      3'b110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 34);
      add("rem_pos",  3'b110, 32'h7,        32'hFFFFFFFE, 32'h1,        34);
      add("divu_big", 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h0,        34);
      add("divu_one", 3'b101, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 34);
      add("divu_z",   3'b101, 32'h12345678, 32'h0,        32'hFFFFFFFF, 1);
      add("remu_z",   3'b111, 32'h12345678, 32'h0,        32'h12345678, 1);
      add("div_ovf",  3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      add("rem_ovf",  3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1);
      add("remu",     3'b111, 32'd100,      32'd7,        32'd2,        34);
      add("divu",     3'b101, 32'd100,      32'd7,        32'd14,       34);

      #12;
      chk("rst_busy",   32'(bus.busy),  32'd0);
      chk("rst_done",   32'(bus.done),  32'd0);
      chk("rst_result", bus.result,     32'd0);
      chk("rst_stall",  32'(bus.stall), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      foreach (tv[i]) run_op(tv[i]);
      prior = tv[tv.size()-1].r;

      // Flush during CALC of a DIV
      @(posedge clk); #1;
      bus.funct3 = 3'b100;
      bus.opa    = 32'd100;
      bus.opb    = 32'd7;
      bus.start  = 1'b1;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.done) seen = 1;
         if (c == 10) chk("flush_busy_c10", 32'(bus.busy), 32'd1);
         if (c == 11) chk("flush_busy_c11", 32'(bus.busy), 32'd0);
         @(posedge clk); #1;
         if (c == 9) begin
            bus.flush = 1'b1;
            bus.start = 1'b0;
         end
         if (c == 10) bus.flush = 1'b0;
      end
      chk("flush_no_done", 32'(seen), 32'd0);
      chk("flush_result_kept", bus.result, prior);
      begin
         vec_t v;
         v.nm = "mul_after_flush"; v.f = 3'b000;
         v.a = 32'd3; v.b = 32'd5; v.r = 32'd15; v.lat = 34;
         run_op(v);
      end

      // Asynchronous reset mid-CALC
      @(posedge clk); #1;
      bus.funct3 = 3'b000;
      bus.opa    = 32'd4;
      bus.opb    = 32'd5;
      bus.start  = 1'b1;
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("arst_busy",   32'(bus.busy),  32'd0);
      chk("arst_done",   32'(bus.done),  32'd0);
      chk("arst_result", bus.result,     32'd0);
      chk("arst_stall_hi", 32'(bus.stall), 32'd1);
      bus.start = 1'b0;
      #1;
      chk("arst_stall_lo", 32'(bus.stall), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Back-to-back with start held high
      @(posedge clk); #1;
      bus.funct3 = 3'b000;
      bus.opa    = 32'd2;
      bus.opb    = 32'd3;
      bus.start  = 1'b1;
      ndone = 0; t1 = -1; t2 = -1;
      for (int c = 0; c < 150 && ndone < 2; c++) begin
         @(negedge clk);
         if (bus.done) begin
            if (ndone == 0) begin
               t1 = c;
               chk("b2b_first", bus.result, 32'd6);
               bus.opa = 32'd4;
               bus.opb = 32'd5;
            end else begin
               t2 = c;
               chk("b2b_second", bus.result, 32'd20);
               bus.start = 1'b0;
            end
            ndone++;
         end
         @(posedge clk); #1;
      end
      chk("b2b_done_count", 32'(ndone), 32'd2);
      chk("b2b_first_cycle", 32'(t1), 32'd34);
      chk("b2b_spacing", 32'(t2 - t1), 32'd35);
      bus.start = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative sequencer for the RV32M multiply/divide operations that the decoder maps to `ALU_MUL`, `ALU_DIV` and `ALU_REM`. It sits beside the single-cycle ALU in EX and accepts operands plus `funct3` when an M-extension instruction reaches EX. While it computes over 32 shift iterations, it holds the pipeline with a stall. It returns the 32-bit result with a one-cycle done strobe.

## Interface
- `XLEN`, default 32: operand/result width. Only 32 is supported. The iteration counter is `$clog2(XLEN)+1` bits.

- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start` in 1: EX holds an M-extension instruction. It stays high until `done`.
- `funct3` in 3: operation select.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `opa` in 32: rs1 value (multiplicand / dividend).
- `opb` in 32: rs2 value (multiplier / divisor).
- `flush` in 1: squash the in-flight operation (branch mispredict / exception).
- `busy` out 1: state ≠ IDLE.
- `stall` out 1: combinational `start & ~done`. Freezes PC, IF/ID and ID/EX.
- `done` out 1: registered. High for exactly one cycle while `result` is valid.
- `result` out 32: registered. Holds its value until the next completion.

## Operation
- States are IDLE, CALC, FIX, DONE.
- **IDLE, on `start & ~flush`:**
  - Latch `funct3`, `opa`, `opb`.
  - Form magnitudes: operand is signed for MUL/MULH/DIV/REM (both); MULHSU (opa only). All other cases are unsigned.
  - Record the negate flags, load counter = 0, then take the first matching branch:
    - `opb == 0` and op is DIV/DIVU/REM/REMU: go to DONE with the div-by-zero result.
    - op is DIV/REM, `opa == 0x80000000` and `opb == 0xFFFFFFFF`: go to DONE with the overflow result.
    - Otherwise: go to CALC.
- **CALC:** one iteration per cycle, 32 iterations, then go to FIX.
  - Multiply: unsigned shift-add into a 64-bit accumulator.
  - Divide: restoring; shift the 64-bit remainder:quotient pair left 1, trial-subtract the divisor magnitude, set the quotient bit if the result is non-negative.
- **FIX:** apply the sign correction, then write `result`.
  - Product is negated (two's complement, 64-bit) iff the operand signs differ. MUL takes product[31:0]; MULH/MULHSU/MULHU take product[63:32].
  - Quotient is negated iff the signs differ (DIV only). Remainder takes the dividend's sign (REM only).
  - Go to DONE.
- **DONE:** `done = 1`, then go to IDLE.
  - A `start` seen in IDLE on the following cycle is treated as a new instruction.
- **Special results:**
  - Divide by zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → `opa`.
  - Overflow: DIV → 0x80000000; REM → 0.
- **`flush`:** wins over every other condition in every state. Go to IDLE on the next edge, no `done`, `result` unchanged. `flush` in DONE suppresses nothing already presented.
- **Stability:** input changes after acceptance are ignored; computation uses only the latched values.
- **Reset:** state IDLE, counter 0, `done` 0, `result` 0, `busy` 0, internal registers 0.

## Timing
- Cycle 0 is the IDLE cycle in which `start` is sampled.
- Normal path: CALC on cycles 1–32, FIX on cycle 33, `done`/`result` valid on cycle 34. `stall` is high on cycles 0–33 and low on cycle 34.
- Special case (div-by-zero, overflow): `done` on cycle 1; `stall` high only on cycle 0.
- `start` held high through DONE does not restart. The block returns to IDLE before sampling `start` again, so back-to-back operations are 35 cycles apart (normal path).
- `rst` assertion mid-CALC: all outputs take their reset values immediately (asynchronous). The operation is lost; `stall` then follows `start` alone.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → `result` 0xFFFFFFEB, `done` on cycle 34, `stall` high on cycles 0–33.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 0x12345678 / 0 → 0xFFFFFFFF, `done` on cycle 1. REMU same operands → 0x12345678. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, `done` on cycle 1. REM same operands → 0.
- Flush and reset:
  - `flush` on cycle 10 of a DIV: IDLE on cycle 11, no `done`, `result` keeps its prior value; a new MUL 3×5 started afterwards returns 15.
  - `rst` low mid-CALC: `busy`/`done`/`result` go to 0 without waiting for a clock edge.
- Back-to-back MUL 2×3 then MUL 4×5 with `start` held high across them: `done` twice, results 6 then 20, second `done` 35 cycles after the first.
